beam_thresh_loader: RTL and testbench

BEAM_THRESH_LOADER -- requirements
Module: beam_thresh_loader

---
 rtl/beam_thresh_loader.sv | 150 +++++++++++++++
 tb/tb_beam_thresh_loader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_thresh_loader.sv
// Threshold loader for the dual-beam threshold units. It walks DEFAULT_THRESH into every beam
// after reset, then streams host writes onto a shared bus and broadcasts commit strobes.
module beam_thresh_loader #(
    parameter int          NBEAMS         = 48,
    parameter logic [17:0] DEFAULT_THRESH = 18'h3FFFF,
    parameter int          AW             = $clog2(NBEAMS)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [17:0]       thresh_dat_i,
    input  logic [AW-1:0]     thresh_addr_i,
    input  logic              thresh_valid_i,
    output logic              thresh_ready_o,
    input  logic              update_req_i,
    output logic [17:0]       thresh_o,
    output logic [NBEAMS-1:0] thresh_ce_o,
    output logic              update_o,
    output logic              dirty_o,
    output logic              init_done_o,
    output logic              bad_addr_o
);

    typedef enum logic [1:0] {
        INIT_LOAD   = 2'd0,
        INIT_UPDATE = 2'd1,
        RUN         = 2'd2
    } state_t;

    localparam int                LIM_W     = AW + 1;
    localparam logic [LIM_W-1:0]  BEAM_LIM  = LIM_W'(NBEAMS);
    localparam logic [AW-1:0]     LAST_BEAM = AW'(NBEAMS - 1);
    localparam logic [NBEAMS-1:0] CE_ONE    = {{(NBEAMS-1){1'b0}}, 1'b1};

    state_t             state_r, state_s;
    logic [AW-1:0]      beam_r, beam_s;
    logic [17:0]        thresh_r, thresh_s;
    logic [NBEAMS-1:0]  ce_r, ce_s;
    logic               update_r, update_s;
    logic               pending_r, pending_s;
    logic               dirty_r, dirty_s;
    logic               init_done_r, init_done_s;
    logic               bad_r, bad_s;
    logic               accept_s;
    logic               in_range_s;

    function automatic logic [NBEAMS-1:0] beam_onehot(input logic [AW-1:0] beam);
        beam_onehot = CE_ONE << beam;
    endfunction

    assign thresh_ready_o = init_done_r & ~pending_r;
    assign accept_s       = thresh_valid_i & thresh_ready_o;
    assign in_range_s     = ({1'b0, thresh_addr_i} < BEAM_LIM);

    assign thresh_o    = thresh_r;
    assign thresh_ce_o = ce_r;
    assign update_o    = update_r;
    assign dirty_o     = dirty_r;
    assign init_done_o = init_done_r;
    assign bad_addr_o  = bad_r;

    // Next-state and next-output logic for the init walk, commit and write path.
    always_comb begin
        state_s     = state_r;
        beam_s      = beam_r;
        thresh_s    = thresh_r;
        ce_s        = '0;
        update_s    = 1'b0;
        pending_s   = pending_r;
        bad_s       = 1'b0;
        init_done_s = (state_r == RUN);

        // A visible load always wins over a clear; the two never share a cycle.
        if (ce_r != '0) begin
            dirty_s = 1'b1;
        end else if (update_r) begin
            dirty_s = 1'b0;
        end else begin
            dirty_s = dirty_r;
        end

        case (state_r)
            INIT_LOAD: begin
                thresh_s  = DEFAULT_THRESH;
                ce_s      = beam_onehot(beam_r);
                pending_s = pending_r | update_req_i;
                if (beam_r == LAST_BEAM) begin
                    beam_s  = '0;
                    state_s = INIT_UPDATE;
                end else begin
                    beam_s  = beam_r + AW'(1);
                    state_s = INIT_LOAD;
                end
            end
            INIT_UPDATE: begin
                // The init strobe also satisfies any request latched during the walk.
                update_s  = 1'b1;
                pending_s = 1'b0;
                state_s   = RUN;
            end
            RUN: begin
                if (accept_s) begin
                    if (in_range_s) begin
                        thresh_s = thresh_dat_i;
                        ce_s     = beam_onehot(thresh_addr_i);
                    end else begin
                        bad_s = 1'b1;
                    end
                    // Defer the commit one cycle so it never overlaps the load.
                    pending_s = pending_r | update_req_i;
                end else if (pending_r || update_req_i) begin
                    update_s  = 1'b1;
                    pending_s = 1'b0;
                end else begin
                    pending_s = pending_r;
                end
            end
            default: begin
                state_s   = INIT_LOAD;
                beam_s    = '0;
                pending_s = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset back to the start of the init walk.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= INIT_LOAD;
            beam_r      <= '0;
            thresh_r    <= 18'h00000;
            ce_r        <= '0;
            update_r    <= 1'b0;
            pending_r   <= 1'b0;
            dirty_r     <= 1'b0;
            init_done_r <= 1'b0;
            bad_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            beam_r      <= beam_s;
            thresh_r    <= thresh_s;
            ce_r        <= ce_s;
            update_r    <= update_s;
            pending_r   <= pending_s;
            dirty_r     <= dirty_s;
            init_done_r <= init_done_s;
            bad_r       <= bad_s;
        end
    end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Scoreboard bench for beam_thresh_loader: stimulus pushes expected bus events tagged with their
// cycle, and a negedge monitor pops and compares every ce/update/bad_addr event the DUT shows.
module tb_beam_thresh_loader;

    localparam int          NB  = 48;
    localparam int          AW  = 6;
    localparam logic [17:0] DEF = 18'h3FFFF;

    typedef struct {
        int             cyc;
        logic [NB-1:0]  ce;
        logic [17:0]    th;
        logic           upd;
        logic           bad;
    } ev_t;

    logic           clk;
    logic           rst;
    logic [17:0]    dat;
    logic [AW-1:0]  addr;
    logic           valid;
    logic           ready;
    logic           req;
    logic [17:0]    thresh;
    logic [NB-1:0]  ce;
    logic           upd;
    logic           dirty;
    logic           init_done;
    logic           bad;

    ev_t exp_q[$];
    ev_t mon_e;
    int  cyc;
    int  checks;
    int  errors;

    beam_thresh_loader #(.NBEAMS(NB), .DEFAULT_THRESH(DEF), .AW(AW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .thresh_dat_i   (dat),
        .thresh_addr_i  (addr),
        .thresh_valid_i (valid),
        .thresh_ready_o (ready),
        .update_req_i   (req),
        .thresh_o       (thresh),
        .thresh_ce_o    (ce),
        .update_o       (upd),
        .dirty_o        (dirty),
        .init_done_o    (init_done),
        .bad_addr_o     (bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NB-1:0] bit_of(input int k);
        logic [NB-1:0] one;
        one = 1;
        return one << k;
    endfunction

    task automatic push_ev(input int c, input logic [NB-1:0] e_ce, input logic [17:0] e_th,
                           input logic e_upd, input logic e_bad);
        ev_t e;
        e.cyc = c; e.ce = e_ce; e.th = e_th; e.upd = e_upd; e.bad = e_bad;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ce"}, 64'(ce), 64'h0);
        chk({nm, "_upd"}, 64'(upd), 64'h0);
        chk({nm, "_dirty"}, 64'(dirty), 64'h0);
        chk({nm, "_init_done"}, 64'(init_done), 64'h0);
        chk({nm, "_bad"}, 64'(bad), 64'h0);
        chk({nm, "_ready"}, 64'(ready), 64'h0);
        chk({nm, "_thresh"}, 64'(thresh), 64'h0);
    endtask

    // Release reset and follow the init walk; abort_at>0 pulses reset after that many beams.
    task automatic init_walk(input int abort_at, input int req_at);
        int c0;
        int nb;
        int last;
        c0   = cyc;
        rst  = 1'b0;
        nb   = (abort_at > 0) ? abort_at : NB;
        last = (abort_at > 0) ? abort_at : NB + 1;
        for (int k = 0; k < nb; k++) push_ev(c0 + 1 + k, bit_of(k), DEF, 1'b0, 1'b0);
        if (abort_at == 0) push_ev(c0 + NB + 1, '0, DEF, 1'b1, 1'b0);
        for (int i = 1; i <= last; i++) begin
            step();
            req = (req_at > 0) && (i == req_at || i == req_at + 3 || i == req_at + 7);
        end
        req = 1'b0;
        if (abort_at > 0) begin
            rst = 1'b1;
            step();
            chk_all_zero("mid_init_rst");
        end else begin
            chk("init_done_early", 64'(init_done), 64'h0);
            step();
            chk("init_done", 64'(init_done), 64'h1);
            chk("init_ready", 64'(ready), 64'h1);
            chk("init_dirty", 64'(dirty), 64'h0);
        end
    endtask

    // Scoreboard monitor: every visible bus event must match the head of the expected queue.
    always @(negedge clk) begin
        if (ce != '0 || upd == 1'b1 || bad == 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d ce=%h thresh=%h upd=%b bad=%b",
                         cyc, ce, thresh, upd, bad);
            end else begin
                mon_e = exp_q.pop_front();
                if (cyc != mon_e.cyc || ce !== mon_e.ce || thresh !== mon_e.th ||
                    upd !== mon_e.upd || bad !== mon_e.bad || $countones(ce) > 1) begin
                    errors++;
                    $display("FAIL event got cyc=%0d ce=%h thresh=%h upd=%b bad=%b expected cyc=%0d ce=%h thresh=%h upd=%b bad=%b",
                             cyc, ce, thresh, upd, bad, mon_e.cyc, mon_e.ce, mon_e.th, mon_e.upd, mon_e.bad);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        checks = 0;
        errors = 0;
        rst = 1'b1; valid = 1'b0; addr = '0; dat = 18'h00000; req = 1'b0;
        repeat (3) step();
        chk_all_zero("reset");

        // Power-on walk.
        init_walk(0, 0);

        // Single write then commit.
        c = cyc;
        valid = 1'b1; addr = 6'd5; dat = 18'd13880;
        push_ev(c + 1, bit_of(5), 18'd13880, 1'b0, 1'b0);
        step();
        valid = 1'b0;
        chk("wr_dirty_t1", 64'(dirty), 64'h0);
        step();
        chk("wr_dirty_t2", 64'(dirty), 64'h1);
        c = cyc;
        req = 1'b1;
        push_ev(c + 1, '0, 18'd13880, 1'b1, 1'b0);
        step();
        req = 1'b0;
        chk("upd_dirty_hold", 64'(dirty), 64'h1);
        chk("upd_ready", 64'(ready), 64'h1);
        step();
        chk("upd_dirty_clr", 64'(dirty), 64'h0);

        // Write and update request on the same edge.
        c = cyc;
        valid = 1'b1; addr = 6'd2; dat = 18'h2A5A5; req = 1'b1;
        push_ev(c + 1, bit_of(2), 18'h2A5A5, 1'b0, 1'b0);
        push_ev(c + 2, '0, 18'h2A5A5, 1'b1, 1'b0);
        step();
        valid = 1'b0; req = 1'b0;
        chk("coll_ready_low", 64'(ready), 64'h0);
        step();
        chk("coll_ready_back", 64'(ready), 64'h1);
        step();
        chk("coll_dirty_clr", 64'(dirty), 64'h0);

        // Out-of-range write while clean.
        c = cyc;
        valid = 1'b1; addr = 6'd50; dat = 18'h11111;
        push_ev(c + 1, '0, 18'h2A5A5, 1'b0, 1'b1);
        step();
        valid = 1'b0;
        step();
        chk("bad_clean_dirty", 64'(dirty), 64'h0);

        // In-range write then two out-of-range writes while dirty.
        c = cyc;
        valid = 1'b1; addr = 6'd10; dat = 18'h00ABC;
        push_ev(c + 1, bit_of(10), 18'h00ABC, 1'b0, 1'b0);
        step();
        addr = 6'd48; dat = 18'h3C3C3;
        push_ev(c + 2, '0, 18'h00ABC, 1'b0, 1'b1);
        step();
        addr = 6'd63; dat = 18'h12345;
        push_ev(c + 3, '0, 18'h00ABC, 1'b0, 1'b1);
        step();
        valid = 1'b0;
        step();
        chk("bad_dirty_hold", 64'(dirty), 64'h1);
        c = cyc;
        req = 1'b1;
        push_ev(c + 1, '0, 18'h00ABC, 1'b1, 1'b0);
        step();
        req = 1'b0;
        step();
        chk("bad_commit_clr", 64'(dirty), 64'h0);

        // Reset during init, then a full init with requests latched during the walk.
        rst = 1'b1;
        step();
        step();
        chk_all_zero("rst_run");
        init_walk(20, 5);
        init_walk(0, 4);

        // Stream 48 writes, addresses 47..0; requests on the last write and the next edge.
        c = cyc;
        for (int i = 0; i < NB; i++) begin
            valid = 1'b1;
            addr  = AW'(NB - 1 - i);
            dat   = 18'(i * 1000 + 7);
            req   = (i == NB - 1);
            push_ev(c + 1 + i, bit_of(NB - 1 - i), 18'(i * 1000 + 7), 1'b0, 1'b0);
            step();
        end
        valid = 1'b0;
        chk("stream_ready_low", 64'(ready), 64'h0);
        req = 1'b1;
        push_ev(c + NB + 1, '0, 18'((NB - 1) * 1000 + 7), 1'b1, 1'b0);
        step();
        req = 1'b0;
        chk("stream_dirty", 64'(dirty), 64'h1);
        step();
        chk("stream_dirty_clr", 64'(dirty), 64'h0);
        repeat (4) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events never seen, first at cyc %0d",
                     exp_q.size(), exp_q[0].cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
